// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   * MDOp operation encodings (mdop_e)
//   * default values for WIDTH, MULT_CYCLES and DIV_CYCLES
//   * width of the busy-cycle counter
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Wide enough for the longest legal latency (31 cycles).
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdop_e;

endpackage

// File: rtl/mdu_calc.sv
// -----------------------------------------------------------------------------
// mdu_calc -- purely combinational result datapath of the MDU.
// Computes {hi, lo} for the latched operation; the sequencing around it lives
// in mdu.
//
// Ports:
//   op_i  [2:0]     latched MDOp (only MULT/MULTU/DIV/DIVU are meaningful)
//   a_i   [WIDTH]   latched first operand
//   b_i   [WIDTH]   latched second operand
//   hi_o  [WIDTH]   HI result (product upper half / remainder)
//   lo_o  [WIDTH]   LO result (product lower half / quotient)
//
// Configuration macro: MDU_DIV_EN -- when undefined the divider is not built
// and divide opcodes produce zero here (mdu never issues them in that build).
// -----------------------------------------------------------------------------
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // Operands extended to 2*WIDTH so one multiplier of each kind yields the
    // full double-width product.
    logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
    logic        [2*WIDTH-1:0] a_zx, b_zx, prod_u;

    assign a_sx   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_sx   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign a_zx   = {{WIDTH{1'b0}}, a_i};
    assign b_zx   = {{WIDTH{1'b0}}, b_i};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

`ifdef MDU_DIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] a_s, b_s, quot_s, rem_s;
    logic                    div_zero, div_ovf;

    assign a_s      = a_i;
    assign b_s      = b_i;
    assign div_zero = (b_i == '0);
    assign div_ovf  = (a_i == MOST_NEG) && (&b_i);
    // SV signed / and % truncate toward zero; remainder follows the dividend.
    // Guarded operands keep the divider away from the zero/overflow cases.
    assign quot_s   = (div_zero || div_ovf) ? '0 : a_s / b_s;
    assign rem_s    = (div_zero || div_ovf) ? '0 : a_s % b_s;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        hi_o = '0;
        lo_o = '0;
        case (op_i)
            OP_MULT: begin
                hi_o = prod_s[2*WIDTH-1:WIDTH];
                lo_o = prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
                hi_o = prod_u[2*WIDTH-1:WIDTH];
                lo_o = prod_u[WIDTH-1:0];
            end
`ifdef MDU_DIV_EN
            OP_DIV: begin
                if (div_zero) begin
                    hi_o = a_i;
                    lo_o = '1;
                end else if (div_ovf) begin
                    hi_o = '0;
                    lo_o = a_i;
                end else begin
                    hi_o = rem_s;
                    lo_o = quot_s;
                end
            end
            OP_DIVU: begin
                if (div_zero) begin
                    hi_o = a_i;
                    lo_o = '1;
                end else begin
                    hi_o = a_i % b_i;
                    lo_o = a_i / b_i;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multi-cycle multiply/divide unit with HI/LO registers.
// An operation is accepted on a rising edge with Start=1 and Busy=0. MULT/DIV
// style ops latch their operands and run for a fixed number of cycles, then
// write HI/LO on the edge where the counter reaches zero. MTHI/MTLO write
// immediately.
//
// Ports:
//   clk          clock, all state changes on rising edge
//   Reset        asynchronous active-low reset
//   Start        one-cycle issue request
//   MDOp  [2:0]  operation code (see mdu_pkg::mdop_e)
//   A, B  [W]    operands
//   Busy         registered, high while an operation is in flight
//   HI, LO [W]   registered result registers
//
// Configuration macro: MDU_DIV_EN -- defined: DIV/DIVU supported; undefined:
// no divider, DIV/DIVU act as NOP.
// -----------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] calc_hi, calc_lo;

    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_o (calc_hi),
        .lo_o (calc_lo)
    );

    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;

        if (busy_q) begin
            // Start is ignored while busy, including on the completion edge.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                hi_d = calc_hi;
                lo_d = calc_lo;
            end
        end else if (Start) begin
            case (MDOp)
                OP_MULT, OP_MULTU: begin
                    op_d  = MDOp;
                    a_d   = A;
                    b_d   = B;
                    cnt_d = MULT_LOAD;
                end
                OP_DIV, OP_DIVU: begin
                    if (DIV_EN) begin
                        op_d  = MDOp;
                        a_d   = A;
                        b_d   = B;
                        cnt_d = DIV_LOAD;
                    end
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end

        // Busy mirrors "counter nonzero", registered alongside the counter.
        busy_d = (cnt_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            // The operand latches are cleared as well, not just HI/LO, so the
            // block has no X state visible through the result datapath.
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu -- directed self-checking bench for mdu (WIDTH=32, 5/10 cycles).
// Inputs change and outputs are sampled on the falling edge of clk.
// Divide expectations follow the MDU_DIV_EN build option.
// -----------------------------------------------------------------------------
module tb_mdu;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [2:0]   MDOp;
    logic [W-1:0] A, B;
    logic         Busy;
    logic [W-1:0] HI, LO;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu #(
        .WIDTH       (W),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present the request for one edge, then scramble A/B so a result that
    // used live inputs instead of latched ones shows up.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        MDOp  = OP_NOP;
        A     = ~a;
        B     = ~b ^ 32'h5A5A_0001;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (Busy !== 1'b0 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_cyc,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cyc;
        issue(op, a, b);
        wait_idle(cyc);
        check({tag, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, " hi"}, 64'(HI), 64'(exp_hi));
        check({tag, " lo"}, 64'(LO), 64'(exp_lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        Reset = 1'b0;
        Start = 1'b0;
        MDOp  = OP_NOP;
        A     = '0;
        B     = '0;

        #12;
        check("reset busy", 64'(Busy), 64'd0);
        check("reset hi",   64'(HI),   64'd0);
        check("reset lo",   64'(LO),   64'd0);
        @(negedge clk);
        Reset = 1'b1;

        // Multiplies, signed vs unsigned on the same bit patterns.
        run_op("mult -3*4",     OP_MULT,  32'hFFFF_FFFD, 32'd4,         5, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
        run_op("multu ff*ff",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -1*-1",    OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001);
        run_op("mult max*max",  OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 32'h3FFF_FFFF, 32'h0000_0001);
        run_op("mult min*2",    OP_MULT,  32'h8000_0000, 32'd2,         5, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("multu min*2",   OP_MULTU, 32'h8000_0000, 32'd2,         5, 32'h0000_0001, 32'h0000_0000);

        // Zero-latency moves and no-ops.
        run_op("mtlo",          OP_MTLO,  32'h0000_0055, 32'd9,         0, 32'h0000_0001, 32'h0000_0055);
        run_op("nop",           OP_NOP,   32'hAAAA_AAAA, 32'd9,         0, 32'h0000_0001, 32'h0000_0055);
        run_op("reserved",      OP_RSVD,  32'hAAAA_AAAA, 32'd9,         0, 32'h0000_0001, 32'h0000_0055);

        // MTHI while busy is ignored; HI/LO frozen mid-flight.
        issue(OP_MULT, 32'd6, 32'd7);
        @(negedge clk);
        Start = 1'b1;
        MDOp  = OP_MTHI;
        A     = 32'h0000_1234;
        @(negedge clk);
        Start = 1'b0;
        MDOp  = OP_NOP;
        check("busy mthi ignored hi", 64'(HI), 64'h1);
        check("busy lo frozen",       64'(LO), 64'h55);
        wait_idle(cyc);
        check("mult 6*7 remaining cycles", 64'(cyc), 64'd3);
        check("mult 6*7 hi", 64'(HI), 64'h0);
        check("mult 6*7 lo", 64'(LO), 64'h2A);
        run_op("mthi after mult", OP_MTHI, 32'h0000_1234, 32'd0, 0, 32'h0000_1234, 32'h0000_002A);

        // Start held across the completion edge: rejected there, taken next.
        issue(OP_MULTU, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        check("last busy cycle", 64'(Busy), 64'd1);
        Start = 1'b1;
        MDOp  = OP_MTLO;
        A     = 32'h0000_ABCD;
        @(negedge clk);
        check("completion edge busy", 64'(Busy), 64'd0);
        check("completion edge hi",   64'(HI),   64'h0);
        check("completion edge lo",   64'(LO),   64'hF);
        @(negedge clk);
        Start = 1'b0;
        MDOp  = OP_NOP;
        check("held start busy", 64'(Busy), 64'd0);
        check("held start lo",   64'(LO),   64'hABCD);

`ifdef MDU_DIV_EN
        run_op("divu 7/2",       OP_DIVU, 32'd7,         32'd2,         10, 32'd1,         32'd3);
        run_op("div -7/2",       OP_DIV,  32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 5/0",        OP_DIV,  32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF);
        run_op("divu 9/0",       OP_DIVU, 32'd9,         32'd0,         10, 32'd9,         32'hFFFF_FFFF);
        run_op("div min/-1",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);
        run_op("div 7/-2",       OP_DIV,  32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD);
        run_op("divu big/3",     OP_DIVU, 32'hFFFF_FFF9, 32'd3,         10, 32'd0,         32'h5555_5553);
        issue(OP_DIV, 32'd100, 32'd7);
`else
        run_op("divu disabled",  OP_DIVU, 32'd7,         32'd2,         0,  32'd0,         32'h0000_ABCD);
        run_op("div disabled",   OP_DIV,  32'd5,         32'd0,         0,  32'd0,         32'h0000_ABCD);
        issue(OP_MULT, 32'd100, 32'd7);
`endif

        // Asynchronous reset part-way through an operation.
        repeat (2) @(negedge clk);
        check("pre-reset busy", 64'(Busy), 64'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("async reset busy", 64'(Busy), 64'd0);
        check("async reset hi",   64'(HI),   64'd0);
        check("async reset lo",   64'(LO),   64'd0);
        @(negedge clk);
        Reset = 1'b1;
        Start = 1'b1;
        MDOp  = OP_MULTU;
        A     = 32'd2;
        B     = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        MDOp  = OP_NOP;
        A     = 32'd11;
        B     = 32'd13;
        check("first edge after reset busy", 64'(Busy), 64'd1);
        check("no partial write hi", 64'(HI), 64'd0);
        check("no partial write lo", 64'(LO), 64'd0);
        wait_idle(cyc);
        check("multu 2*3 cycles", 64'(cyc), 64'd5);
        check("multu 2*3 hi",     64'(HI),  64'd0);
        check("multu 2*3 lo",     64'(LO),  64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width in bits; legal values are 16, 32 and 64.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for a multiply; legal range 1..31.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for a divide; legal range 1..31.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset (Reset=0 resets).
REQ-006 Start  in  1  one-cycle request to issue MDOp with operands A and B.
REQ-007 MDOp  in  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is reserved and acts as NOP.
REQ-008 A  in  WIDTH  first operand (rs value).
REQ-009 B  in  WIDTH  second operand (rt value).
REQ-010 Busy  out  1  registered; high while an operation is in flight.
REQ-011 HI  out  WIDTH  registered HI register.
REQ-012 LO  out  WIDTH  registered LO register.

Function
REQ-013 An operation is accepted only at a rising edge where Start=1 and Busy=0; while Busy=1, Start is ignored and HI/LO do not change.
REQ-014 On accepting MULT, MULTU, DIV or DIVU, the block latches A, B and MDOp and loads the cycle counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 Busy is 1 exactly when the counter is nonzero, so an op accepted at edge k holds Busy=1 from k+1 through k+N and Busy=0 after edge k+N.
REQ-016 At edge k+N (counter going from 1 to 0), HI/LO are written from the latched operands; later changes on A/B have no effect on the result.
REQ-017 MULT and MULTU form a 2*WIDTH-bit product, signed or unsigned respectively; HI receives the upper half and LO the lower half.
REQ-018 DIV and DIVU write the quotient to LO and the remainder to HI; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-019 For a divide by zero (B=0), HI=A and LO=all ones, for both DIV and DIVU.
REQ-020 For the signed overflow case DIV with A=most negative value and B=-1, LO=A and HI=0.
REQ-021 MTHI and MTLO write A into HI or LO at the accepting edge itself, with zero latency; Busy stays 0.
REQ-022 NOP and reserved codes change nothing.
REQ-023 When the completion edge and a new Start fall in the same cycle, Busy is still 1 during that cycle, so the new Start is rejected; the issuing stage holds Start until it sees Busy=0.

Reset
REQ-024 Reset=0 immediately clears HI, LO, the counter, the latched operands and Busy to 0, independent of clk.
REQ-025 Reset asserted during an in-flight operation aborts it; no partial result is ever written to HI/LO.
REQ-026 After Reset is released, the first rising edge accepts Start normally.

Configuration
REQ-027 Macro MDU_DIV_EN defined: DIV and DIVU behave as in REQ-014 to REQ-020.
REQ-028 Macro MDU_DIV_EN undefined: no divider logic is synthesised; DIV and DIVU are treated as NOP and Busy stays 0.

Structure
REQ-029 Package mdu_pkg holds the MDOp encodings, the default values of WIDTH, MULT_CYCLES and DIV_CYCLES, and the counter width (5).
REQ-030 Sub-module mdu_calc (combinational) takes the latched operands and op and returns {hi,lo}; the divide path inside it is guarded by MDU_DIV_EN.
REQ-031 Module mdu contains the counter, the operand latches, the Busy logic and the HI/LO registers.

Verification
REQ-032 MULT A=-3 (0xFFFFFFFD), B=4 -> Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFF4.
REQ-033 DIVU A=7, B=2 -> Busy=1 for exactly 10 cycles, then LO=3 and HI=1; DIV A=-7, B=2 -> LO=-3 (0xFFFFFFFD) and HI=-1 (0xFFFFFFFF).
REQ-034 DIV A=5, B=0 -> HI=5 and LO=0xFFFFFFFF; DIV A=0x80000000, B=-1 -> LO=0x80000000 and HI=0.
REQ-035 Start MTHI A=0x1234 during a MULT -> ignored; after the MULT completes, MTHI writes HI=0x1234 on the next edge while Busy stays 0.
REQ-036 Reset pulsed at cycle 3 of a DIV -> HI=LO=0 and Busy=0 at once; a new MULTU 2*3 issued afterwards -> LO=6.
REQ-037 Build with MDU_DIV_EN undefined, issue DIVU 7/2 -> Busy stays 0 and HI/LO are unchanged.
